// File: rtl/inst_encode.sv
// inst_encode: packs RV32I instruction fields into a 32-bit word, rejects
// immediates that cannot be represented, buffers legal words in a small FIFO
// and writes them to instruction memory at an auto-incrementing word address.
//
// Handshakes:
//   request side : a request is consumed on a rising edge where in_valid and
//                  in_ready are both high. in_ready depends only on FIFO
//                  occupancy, never on in_valid or mem_ready.
//   memory side  : mem_we is high whenever the FIFO holds a word; the write
//                  completes on a rising edge where mem_we and mem_ready are
//                  both high. mem_we/mem_addr/mem_wdata stay stable until then.
module inst_encode #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            inst_type,
   input  logic [6:0]            opcode,
   input  logic [4:0]            rd_addr,
   input  logic [4:0]            rs1_addr,
   input  logic [4:0]            rs2_addr,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic [31:0]           immediate,
   output logic                  mem_we,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  addr_load,
   input  logic [ADDR_WIDTH-1:0] addr_value,
   output logic                  busy,
   output logic                  err,
   output logic [7:0]            err_count
);

   // Instruction-type codes shared with the decode stage.
   localparam logic [3:0] TYPE_R       = 4'd0;
   localparam logic [3:0] TYPE_I       = 4'd1;
   localparam logic [3:0] TYPE_S       = 4'd2;
   localparam logic [3:0] TYPE_B       = 4'd3;
   localparam logic [3:0] TYPE_U       = 4'd4;
   localparam logic [3:0] TYPE_J       = 4'd5;
   localparam logic [3:0] TYPE_INVALID = 4'd15;

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

   // ------------------------------------------------------------------
   // Immediate range checks. A field of N significant bits is legal when
   // every bit above the sign bit is a copy of it.
   // ------------------------------------------------------------------
   logic imm_fits_12;   // I/S: imm[31:11] all equal
   logic imm_fits_13;   // B:   imm[31:12] all equal
   logic imm_fits_21;   // J:   imm[31:20] all equal
   logic imm_even;      // B/J: byte offset must be halfword aligned
   logic imm_low_zero;  // U:   low 12 bits must be zero

   assign imm_fits_12  = (&immediate[31:11]) | ~(|immediate[31:11]);
   assign imm_fits_13  = (&immediate[31:12]) | ~(|immediate[31:12]);
   assign imm_fits_21  = (&immediate[31:20]) | ~(|immediate[31:20]);
   assign imm_even     = ~immediate[0];
   assign imm_low_zero = ~(|immediate[11:0]);

   // ------------------------------------------------------------------
   // Encoder
   // ------------------------------------------------------------------
   logic [31:0] enc_word;
   logic        enc_legal;

   // Pack the fields for the requested format and decide legality.
   always_comb begin
      enc_word  = 32'd0;
      enc_legal = 1'b0;
      case (inst_type)
         TYPE_R: begin
            enc_word  = {funct7, rs2_addr, rs1_addr, funct3, rd_addr, opcode};
            enc_legal = 1'b1;
         end
         TYPE_I: begin
            enc_word  = {immediate[11:0], rs1_addr, funct3, rd_addr, opcode};
            enc_legal = imm_fits_12;
         end
         TYPE_S: begin
            enc_word  = {immediate[11:5], rs2_addr, rs1_addr, funct3,
                         immediate[4:0], opcode};
            enc_legal = imm_fits_12;
         end
         TYPE_B: begin
            enc_word  = {immediate[12], immediate[10:5], rs2_addr, rs1_addr,
                         funct3, immediate[4:1], immediate[11], opcode};
            enc_legal = imm_fits_13 & imm_even;
         end
         TYPE_U: begin
            enc_word  = {immediate[31:12], rd_addr, opcode};
            enc_legal = imm_low_zero;
         end
         TYPE_J: begin
            enc_word  = {immediate[20], immediate[10:1], immediate[11],
                         immediate[19:12], rd_addr, opcode};
            enc_legal = imm_fits_21 & imm_even;
         end
         TYPE_INVALID: begin
            enc_word  = 32'd0;
            enc_legal = 1'b0;
         end
         default: begin
            enc_word  = 32'd0;
            enc_legal = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------
   logic [PTR_W:0]   count;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             accept;
   logic             push;
   logic             reject;
   logic             pop;

   assign in_ready = (count < DEPTH_CNT);
   assign accept   = in_valid & in_ready;
   assign push     = accept & enc_legal;
   assign reject   = accept & ~enc_legal;
   assign busy     = (count != '0);
   assign mem_we   = busy;
   assign pop      = mem_we & mem_ready;

   // ------------------------------------------------------------------
   // FIFO storage. The data array carries no reset: occupancy is tracked by
   // count, and mem_wdata is forced to zero while the FIFO is empty, so stale
   // entries are never visible.
   // ------------------------------------------------------------------
   logic [31:0] fifo_mem [FIFO_DEPTH];

   // Write the encoded word into the tail slot on a legal accept.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[tail] <= enc_word;
      end
   end

   assign mem_wdata = busy ? fifo_mem[head] : 32'd0;

   // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^n).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Write pointer. A load wins over the post-write increment; a write that
   // completes in the same cycle has already used the old address.
   // ------------------------------------------------------------------
   // Track the instruction-memory word address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr <= BASE;
      end else if (addr_load) begin
         mem_addr <= addr_value;
      end else if (pop) begin
         mem_addr <= mem_addr + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Reject reporting
   // ------------------------------------------------------------------
   // One-cycle error pulse and saturating reject counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err       <= 1'b0;
         err_count <= 8'd0;
      end else begin
         err <= reject;
         if (reject && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_inst_encode.sv
// Bench for inst_encode: directed test-plan cases followed by randomized
// requests, with a reference encoder written from the RV32I field rules
// using integer arithmetic, and a write scoreboard fed by an expected queue.
module tb_inst_encode;

  localparam int AW = 10;
  localparam logic [3:0] T_R = 4'd0;
  localparam logic [3:0] T_I = 4'd1;
  localparam logic [3:0] T_S = 4'd2;
  localparam logic [3:0] T_B = 4'd3;
  localparam logic [3:0] T_U = 4'd4;
  localparam logic [3:0] T_J = 4'd5;
  localparam logic [3:0] T_X = 4'd15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    inst_type = '0;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd_addr = '0;
  logic [4:0]    rs1_addr = '0;
  logic [4:0]    rs2_addr = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   immediate = '0;
  logic          mem_we;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          addr_load = 1'b0;
  logic [AW-1:0] addr_value = '0;
  logic          busy;
  logic          err;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  logic [31:0]   exp_q[$];
  logic [AW-1:0] model_addr = '0;
  int            model_errc = 0;
  bit            rand_mode = 1'b0;

  inst_encode #(.FIFO_DEPTH(4), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .opcode(opcode), .rd_addr(rd_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .funct3(funct3),
    .funct7(funct7), .immediate(immediate), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .addr_load(addr_load), .addr_value(addr_value), .busy(busy),
    .err(err), .err_count(err_count)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: field placement by shifting and masking, legality by
  // numeric range of the signed immediate.
  function automatic bit model_encode(input logic [3:0] t, input int op, input int rd,
                                      input int rs1, input int rs2, input int f3,
                                      input int f7, input logic [31:0] imm,
                                      output logic [31:0] w);
    int si;
    bit ok;
    si = $signed(imm);
    w  = 32'd0;
    ok = 1'b0;
    case (t)
      T_R: begin
        ok = 1'b1;
        w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      T_I: begin
        ok = (si >= -2048) && (si <= 2047);
        w  = ((si & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      T_S: begin
        ok = (si >= -2048) && (si <= 2047);
        w  = (((si >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | ((si & 'h1F) << 7) | op;
      end
      T_B: begin
        ok = (si >= -4096) && (si <= 4095) && ((si & 1) == 0);
        w  = (((si >> 12) & 1) << 31) | (((si >> 5) & 'h3F) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((si >> 1) & 'hF) << 8)
             | (((si >> 11) & 1) << 7) | op;
      end
      T_U: begin
        ok = ((si & 'hFFF) == 0);
        w  = (si & 'hFFFFF000) | (rd << 7) | op;
      end
      T_J: begin
        ok = (si >= -(1 << 20)) && (si <= (1 << 20) - 1) && ((si & 1) == 0);
        w  = (((si >> 20) & 1) << 31) | (((si >> 1) & 'h3FF) << 21)
             | (((si >> 11) & 1) << 20) | (((si >> 12) & 'hFF) << 12) | (rd << 7) | op;
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Scoreboard: every completed memory write must match the queue head and
  // the modelled write pointer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we && mem_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
                 mem_addr, mem_wdata);
        end
        if (exp_q.size() > 0) begin
          check("wdata", mem_wdata, exp_q.pop_front());
          check("waddr", 32'(mem_addr), 32'(model_addr));
        end
      end
      if (addr_load) model_addr = addr_value;
      else if (mem_we && mem_ready) model_addr = model_addr + 1'b1;
    end
  end

  // Driver: called at posedge+1; leaves at posedge+1 after the accept edge.
  task automatic send(input logic [3:0] t, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input bit use_lit, input logic [31:0] lit);
    logic [31:0] w;
    bit ok;
    int n;
    inst_type = t; opcode = op; rd_addr = rd; rs1_addr = rs1; rs2_addr = rs2;
    funct3 = f3; funct7 = f7; immediate = imm;
    in_valid = 1'b1;
    if (rand_mode) mem_ready = ($urandom_range(0, 3) != 0);
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      if (rand_mode) mem_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL accept_timeout: observed in_ready %0b expected 1", in_ready);
    end
    ok = model_encode(t, op, rd, rs1, rs2, f3, f7, imm, w);
    if (ok) exp_q.push_back(use_lit ? lit : w);
    else if (model_errc < 255) model_errc++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("err_pulse", {31'd0, err}, {31'd0, !ok});
    check("err_count", {24'd0, err_count}, 32'(model_errc));
  endtask

  // Reset: asserted at posedge+1, outputs checked while held, released
  // at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    exp_q.delete();
    model_addr = '0;
    model_errc = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    mem_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin : main
    logic [AW-1:0] a0;
    logic [31:0]   w0;
    logic [3:0]    types[8];
    logic [31:0]   imm;
    types = '{T_R, T_I, T_S, T_B, T_U, T_J, T_X, 4'd9};

    #2;
    do_reset();

    // I-type and S/B/J/U round trip at consecutive addresses
    mem_ready = 1'b1;
    send(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
    send(T_S, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE21AE23);
    send(T_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8, 1'b1, 32'hFE208CE3);
    send(T_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h001000EF);
    send(T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
    drain();
    check("addr_after_five", 32'(mem_addr), 32'd5);

    // Rejects, then counter saturation
    do_reset();
    mem_ready = 1'b1;
    send(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0);
    send(T_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0);
    send(T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 1'b0, 32'd0);
    send(T_X, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    check("four_rejects", {24'd0, err_count}, 32'd4);
    check("reject_no_write", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 300; i++)
      send(T_X, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    check("err_saturated", {24'd0, err_count}, 32'd255);

    // Backpressure: four fill the FIFO, the fifth waits
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(T_R, 7'h33, 5'(i + 1), 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 1'b0, 32'd0);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    a0 = mem_addr; w0 = mem_wdata;
    inst_type = T_I; opcode = 7'h13; rd_addr = 5'd9; rs1_addr = 5'd9;
    funct3 = 3'd0; immediate = 32'hFFFFF800; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_we", {31'd0, mem_we}, 32'd1);
      check("stall_addr", 32'(mem_addr), 32'(a0));
      check("stall_wdata", mem_wdata, w0);
    end
    mem_ready = 1'b1;
    send(T_I, 7'h13, 5'd9, 5'd9, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 1'b0, 32'd0);
    drain();
    check("bp_addr_end", 32'(mem_addr), 32'd5);

    // Address wrap after a load
    addr_load = 1'b1; addr_value = 10'h3FF;
    @(posedge clk); #1;
    addr_load = 1'b0;
    send(T_U, 7'h17, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 1'b0, 32'd0);
    send(T_U, 7'h37, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 1'b0, 32'd0);
    drain();
    check("wrap_addr", 32'(mem_addr), 32'd1);

    // Load coincident with a completing write
    mem_ready = 1'b0;
    send(T_R, 7'h33, 5'd7, 5'd8, 5'd9, 3'd7, 7'd0, 32'd0, 1'b0, 32'd0);
    send(T_R, 7'h33, 5'd10, 5'd11, 5'd12, 3'd6, 7'd0, 32'd0, 1'b0, 32'd0);
    addr_load = 1'b1; addr_value = 10'h100; mem_ready = 1'b1;
    @(posedge clk); #1;
    addr_load = 1'b0;
    check("load_coincident_addr", 32'(mem_addr), 32'h100);
    drain();
    check("load_after_addr", 32'(mem_addr), 32'h101);

    // Randomized requests with random memory backpressure
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
        2: imm = {$urandom_range(0, 32'hFFFFF), 12'd0};
        default: imm = 32'($signed($urandom_range(0, 32'h1FFFFF)) - 32'h100000);
      endcase
      send(types[$urandom_range(0, 7)], 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 3'($urandom), 7'($urandom), imm, 1'b0, 32'd0);
    end
    rand_mode = 1'b0;
    drain();

    // Reset with three words buffered
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(T_I, 7'h13, 5'(i + 1), 5'd1, 5'd0, 3'd0, 7'd0, 32'(i), 1'b0, 32'd0);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("post_reset_we", {31'd0, mem_we}, 32'd0);
    check("post_reset_addr", 32'(mem_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
